// File: rtl/mem_io_pkg.sv
// Shared definitions for the CPU memory-bus responder: address classes,
// IO register offsets, status-byte bit positions and the address decoder.
package mem_io_pkg;

    // Decode class of a bus address, taken from address bits 17:16.
    typedef enum logic [1:0] {
        ADDR_RAM  = 2'd0,
        ADDR_HOLE = 2'd1,
        ADDR_IO   = 2'd2
    } addr_class_t;

    // IO register offsets within the IO window (address bits 2:0).
    localparam logic [2:0] IO_UART = 3'd0;
    localparam logic [2:0] IO_STAT = 3'd4;

    // Bit positions inside the status byte.
    localparam int STAT_RX_FULL = 0;
    localparam int STAT_TX_FULL = 1;
    localparam int STAT_OVF     = 2;

    // 00/01 -> RAM, 10 -> unmapped hole, 11 -> IO window.
    function automatic addr_class_t decode_class(input logic [1:0] a_hi);
        addr_class_t cls;
        case (a_hi)
            2'b10:   cls = ADDR_HOLE;
            2'b11:   cls = ADDR_IO;
            default: cls = ADDR_RAM;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Synchronous circular-buffer FIFO used for UART transmit data.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   push/push_data write request and byte (accepted if not full, or full
//                  while a pop happens in the same cycle)
//   pop            read request (ignored when empty)
//   full, empty    occupancy flags from the current pointers
//   head           entry at the read pointer (undefined while empty)
//   level_next     occupancy after this cycle's push/pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the low bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign level_next = (wr_ptr - rd_ptr)
                      + (do_push ? PTR_ONE : '0)
                      - (do_pop  ? PTR_ONE : '0);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage arrays are deliberately left out of reset; the pointers
    // alone define which entries are valid, and an unreset array maps onto
    // distributed/block RAM instead of a wall of flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target-side responder for the CPU byte-wide memory bus.
// Serves on-chip RAM with one-cycle read latency plus a small UART window:
// TX FIFO (offset 0 write), RX holding register (offset 0 read, destructive),
// status byte (offset 4 read) and a sticky halt register (offset 4 write).
// Ports:
//   clk_in, rst_n_in       clock, synchronous active-low reset
//   rdy_in                 global enable; low freezes all state
//   cpu_a_in/wr/dout       bus request, one transaction every cycle
//   cpu_din_out            read data, valid the cycle after the request
//   io_buffer_full_out     TX back-pressure with FULL_MARGIN slack
//   tx_data/valid, tx_ready_in   TX FIFO head towards the UART
//   rx_data/valid_in, rx_ready_out  RX byte from the UART
//   halt_out, halt_code_out      program-end flag and its code byte
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_dout_in,
    output logic [7:0]  cpu_din_out,
    output logic        io_buffer_full_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic        halt_out,
    output logic [7:0]  halt_code_out
);

    localparam int LW = $clog2(TX_DEPTH) + 1;

    // Request decode
    addr_class_t       cls;
    logic [2:0]        io_off;
    logic              io_uart_wr;
    logic              io_uart_rd;
    logic              io_stat_wr;

    assign cls        = decode_class(cpu_a_in[17:16]);
    assign io_off     = cpu_a_in[2:0];
    assign io_uart_wr = (cls == ADDR_IO) &&  cpu_wr_in && (io_off == IO_UART);
    assign io_uart_rd = (cls == ADDR_IO) && !cpu_wr_in && (io_off == IO_UART);
    assign io_stat_wr = (cls == ADDR_IO) &&  cpu_wr_in && (io_off == IO_STAT);

    // Only bits 17:0 take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_a_in[31:18];

    // TX FIFO
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [7:0]        tx_head;
    logic [LW-1:0]     tx_level_next;

    assign tx_push = rdy_in && io_uart_wr;
    assign tx_pop  = rdy_in && tx_ready_in && !tx_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .push       (tx_push),
        .push_data  (cpu_dout_in),
        .pop        (tx_pop),
        .full       (tx_full),
        .empty      (tx_empty),
        .head       (tx_head),
        .level_next (tx_level_next)
    );

    // The head slot is stale while empty; present zero instead.
    assign tx_valid_out = !tx_empty;
    assign tx_data_out  = tx_empty ? 8'h00 : tx_head;

    // RAM: writes land at the edge; reads are registered (one-cycle latency).
    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        ram_q;
    logic [RAM_AW-1:0] ram_addr;

    assign ram_addr = cpu_a_in[RAM_AW-1:0];

    always_ff @(posedge clk_in) begin
        if (rdy_in && rst_n_in) begin
            if (cpu_wr_in && (cls == ADDR_RAM)) ram[ram_addr] <= cpu_dout_in;
            ram_q <= ram[ram_addr];
        end
    end

    // Control and IO registers
    addr_class_t       rd_class;
    logic [7:0]        io_rdata;
    logic [7:0]        io_rd_value;
    logic              rx_full;
    logic [7:0]        rx_data;
    logic              ovf;
    logic              io_full;
    logic              halt;
    logic [7:0]        halt_code;

    // IO read data is snapshotted at request time: the RX read empties the
    // holding register in that same cycle.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        io_rd_value = 8'h00;
        if (io_off == IO_UART) begin
            io_rd_value = rx_full ? rx_data : 8'h00;
        end else if (io_off == IO_STAT) begin
            io_rd_value[STAT_RX_FULL] = rx_full;
            io_rd_value[STAT_TX_FULL] = tx_full;
            io_rd_value[STAT_OVF]     = ovf;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rd_class  <= ADDR_HOLE;
            io_rdata  <= 8'h00;
            rx_full   <= 1'b0;
            rx_data   <= 8'h00;
            ovf       <= 1'b0;
            io_full   <= 1'b0;
            halt      <= 1'b0;
            halt_code <= 8'h00;
        end else if (rdy_in) begin
            rd_class <= cls;
            io_rdata <= io_rd_value;

            // Capture and pop are exclusive: a pop needs rx_full, a capture
            // needs it clear, so a byte offered during a pop waits a cycle.
            if (rx_valid_in && !rx_full) begin
                rx_full <= 1'b1;
                rx_data <= rx_data_in;
            end else if (io_uart_rd) begin
                rx_full <= 1'b0;
            end

            if (tx_push && tx_full && !tx_pop) ovf <= 1'b1;

            // Margin leaves room for CPU writes already in flight.
            io_full <= ((TX_DEPTH - int'(tx_level_next)) <= FULL_MARGIN);

            if (io_stat_wr && !halt) begin
                halt      <= 1'b1;
                halt_code <= cpu_dout_in;
            end
        end
    end

    always_comb begin
        cpu_din_out = 8'h00;
        if (rd_class == ADDR_RAM)     cpu_din_out = ram_q;
        else if (rd_class == ADDR_IO) cpu_din_out = io_rdata;
    end

    assign io_buffer_full_out = io_full;
    assign rx_ready_out       = !rx_full;
    assign halt_out           = halt;
    assign halt_code_out      = halt_code;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// queue/array reference model of the bus behaviour.
module tb_mem_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        io_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic [7:0]  halt_code;

    always #5 clk = ~clk;

    mem_io_responder #(
        .RAM_AW      (17),
        .TX_DEPTH    (DEPTH),
        .FULL_MARGIN (MARGIN)
    ) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .rdy_in             (rdy),
        .cpu_a_in           (a),
        .cpu_wr_in          (wr),
        .cpu_dout_in        (dout),
        .cpu_din_out        (din),
        .io_buffer_full_out (io_full),
        .tx_data_out        (tx_data),
        .tx_valid_out       (tx_valid),
        .tx_ready_in        (tx_ready),
        .rx_data_in         (rx_data),
        .rx_valid_in        (rx_valid),
        .rx_ready_out       (rx_ready),
        .halt_out           (halt),
        .halt_code_out      (halt_code)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_ram [int];
    logic [7:0] m_txq [$];
    logic       m_rx_full;
    logic [7:0] m_rx_byte;
    logic       m_ovf;
    logic       m_halt;
    logic [7:0] m_code;
    logic       m_full;
    logic       m_din_known;
    logic [7:0] m_din;

    // Advance the model by one bus cycle using the inputs currently driven.
    task automatic model_update();
        logic       is_ram, is_io;
        logic [2:0] off;
        logic       pre_rx_full;
        int         pre_len;
        int         key;
        if (!rst_n) begin
            m_txq.delete();
            m_rx_full   = 1'b0;
            m_ovf       = 1'b0;
            m_halt      = 1'b0;
            m_code      = 8'h00;
            m_full      = 1'b0;
            m_din       = 8'h00;
            m_din_known = 1'b1;
            return;
        end
        if (!rdy) return;
        is_ram      = (a[17] == 1'b0);
        is_io       = (a[17:16] == 2'b11);
        off         = a[2:0];
        key         = int'(a[16:0]);
        pre_rx_full = m_rx_full;
        pre_len     = m_txq.size();

        if (wr) begin
            m_din_known = 1'b0;
        end else if (is_ram) begin
            m_din_known = m_ram.exists(key);
            if (m_din_known) m_din = m_ram[key];
        end else begin
            m_din_known = 1'b1;
            if (is_io && off == 3'd0)      m_din = pre_rx_full ? m_rx_byte : 8'h00;
            else if (is_io && off == 3'd4) m_din = {5'b0, m_ovf, (pre_len == DEPTH), pre_rx_full};
            else                           m_din = 8'h00;
        end

        if (wr && is_ram) m_ram[key] = dout;

        if (tx_ready && pre_len > 0) void'(m_txq.pop_front());
        if (wr && is_io && off == 3'd0) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(dout);
            else                      m_ovf = 1'b1;
        end

        if (rx_valid && !pre_rx_full) begin
            m_rx_full = 1'b1;
            m_rx_byte = rx_data;
        end else if (!wr && is_io && off == 3'd0) begin
            m_rx_full = 1'b0;
        end

        if (wr && is_io && off == 3'd4 && !m_halt) begin
            m_halt = 1'b1;
            m_code = dout;
        end

        m_full = ((DEPTH - m_txq.size()) <= MARGIN);
    endtask

    task automatic check_model();
        if (m_din_known) check("model din", din, m_din);
        check("model tx_valid", tx_valid, m_txq.size() > 0);
        check("model tx_data", tx_data, (m_txq.size() > 0) ? m_txq[0] : 8'h00);
        check("model rx_ready", rx_ready, !m_rx_full);
        check("model io_full", io_full, m_full);
        check("model halt", halt, m_halt);
        check("model halt_code", halt_code, m_code);
    endtask

    // One bus cycle: model sees pre-edge inputs, outputs sampled 1 after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic [31:0] ai, input logic wi, input logic [7:0] di,
                         input logic tri_, input logic rvi, input logic [7:0] rdi);
        a        = ai;
        wr       = wi;
        dout     = di;
        tx_ready = tri_;
        rx_valid = rvi;
        rx_data  = rdi;
        step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        tx_ready;
        logic        chk_din;
        logic [7:0]  din;
        logic        full;
        logic        tx_valid;
        logic [7:0]  tx_data;
    } vec_t;

    vec_t       vecs [21];
    logic [7:0] drain_exp [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{32'h00000, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h00010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h00010, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00},
            '{32'h20000, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h20000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h00000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00},
            '{32'h1FFFF, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h1FFFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00},
            '{32'h3FFFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00},
            '{32'h30000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h45, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h46, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h47, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h49, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41},
            '{32'h30004, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h41},
            '{32'h30000, 1'b1, 8'h50, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42},
            '{32'h30004, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h42}
        };
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};

        // Reset
        rst_n = 1'b0; rdy = 1'b1;
        a = '0; wr = 1'b0; dout = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        step();
        step();
        check("reset din", din, 8'h00);
        check("reset io_full", io_full, 1'b0);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset rx_ready", rx_ready, 1'b1);
        check("reset halt", halt, 1'b0);
        check("reset halt_code", halt_code, 8'h00);
        rst_n = 1'b1;

        // Table: RAM, hole, IO misc offset, TX fill / overflow / full push+pop
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].a, vecs[i].wr, vecs[i].dout, vecs[i].tx_ready, 1'b0, 8'h00);
            if (vecs[i].chk_din) check($sformatf("vec%0d din", i), din, vecs[i].din);
            check($sformatf("vec%0d io_full", i), io_full, vecs[i].full);
            check($sformatf("vec%0d tx_valid", i), tx_valid, vecs[i].tx_valid);
            check($sformatf("vec%0d tx_data", i), tx_data, vecs[i].tx_data);
        end

        // Drain: order 0x42..0x48 then the byte pushed while full
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d data", i), tx_data, drain_exp[i]);
            check($sformatf("drain%0d valid", i), tx_valid, 1'b1);
            drive(32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
        check("drained valid", tx_valid, 1'b0);
        check("drained data", tx_data, 8'h00);
        check("drained io_full", io_full, 1'b0);
        drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("status ovf sticky", din, 8'h04);

        // RX basic: read returns byte then zero
        drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E);
        check("rx capture ready", rx_ready, 1'b0);
        drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx read1", din, 8'h7E);
        check("rx read1 ready", rx_ready, 1'b1);
        drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx read2", din, 8'h00);

        // RX pop while a new byte is offered: the new byte waits a cycle
        drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h21);
        drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        check("status rx_full", din, 8'h05);
        check("rx held ready", rx_ready, 1'b0);
        drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        check("rx pop data", din, 8'h21);
        check("rx pop ready", rx_ready, 1'b1);
        drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        check("rx late capture", rx_ready, 1'b0);
        drive(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx late data", din, 8'h22);

        // rdy low freezes everything
        drive(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("pre-freeze din", din, 8'hA5);
        rdy = 1'b0;
        drive(32'h00010, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h33);
        check("freeze din", din, 8'hA5);
        check("freeze rx_ready", rx_ready, 1'b1);
        drive(32'h30000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        check("freeze tx_valid", tx_valid, 1'b0);
        rdy = 1'b1;
        drive(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("freeze no write", din, 8'hA5);

        // Halt is sticky
        drive(32'h30004, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
        check("halt set", halt, 1'b1);
        check("halt code", halt_code, 8'h03);
        drive(32'h30004, 1'b1, 8'h09, 1'b0, 1'b0, 8'h00);
        check("halt code kept", halt_code, 8'h03);

        // Mid-operation reset clears registers but keeps RAM
        drive(32'h30000, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00);
        drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
        check("pre-reset tx_valid", tx_valid, 1'b1);
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        check("mid reset din", din, 8'h00);
        check("mid reset io_full", io_full, 1'b0);
        check("mid reset tx_valid", tx_valid, 1'b0);
        check("mid reset tx_data", tx_data, 8'h00);
        check("mid reset rx_ready", rx_ready, 1'b1);
        check("mid reset halt", halt, 1'b0);
        check("mid reset halt_code", halt_code, 8'h00);
        drive(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("mid reset status", din, 8'h00);
        drive(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ram retained", din, 8'hA5);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          sel;
            logic [31:0] ra;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)
                ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15))
                                                 : 32'h1FFF0 + 32'($urandom_range(0, 15));
            else if (sel == 5)
                ra = 32'h20000 + 32'($urandom_range(0, 255));
            else
                ra = 32'h30000 + 32'($urandom_range(0, 7));
            ra = ra | ($urandom & 32'hFFFC_0000);
            rst_n = ($urandom_range(0, 199) != 0);
            rdy   = ($urandom_range(0, 9) != 0);
            drive(ra, ($urandom_range(0, 2) == 0), 8'($urandom),
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 9) < 3), 8'($urandom));
        end
        rst_n = 1'b1;
        rdy   = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
